encryption: RTL

- Streaming character encryptor; the inverse of the decryption block. Consumes lowercase plaintext characters and produces C = (P − SK − Q) mod p, with p = 227 and Q = 225.
- Sits on the transmit side of the cipher datapath.
- Unlike the decryption block it holds its own key register and key FSM. It uses valid/ready handshakes on both sides, with a one-entry output register.

---
 rtl/encryption.sv | 108 ++++++++++
 1 files changed

// File: rtl/encryption.sv
// Streaming lowercase-character encryptor: C = (P - SK - Q) mod p, with its own
// key register and key FSM, valid/ready on both sides, one-entry output register.
module encryption #(
  parameter int P_MOD = 227,
  parameter int Q_OFF = 225,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             key_load,
  input  logic [7:0]       secret_key,
  input  logic             ptxt_valid,
  input  logic [7:0]       ptxt,
  output logic             ptxt_ready,
  output logic             ctxt_valid,
  output logic [7:0]       ctxt,
  input  logic             ctxt_ready,
  output logic             key_valid,
  output logic             err_invalid_seckey,
  output logic             err_invalid_ptxt_char,
  output logic [CNT_W-1:0] char_count
);

  localparam logic [0:0] NO_KEY = 1'b0;
  localparam logic [0:0] KEY_OK = 1'b1;

  localparam logic [1:0] MODE_ENC = 2'b10;
  localparam logic [7:0] P8       = 8'(P_MOD);
  localparam logic [7:0] CHR_LO   = 8'h61;
  localparam logic [7:0] CHR_HI   = 8'h7A;

  // -SK - Q mod p folds to +(p - q) - SK, with one conditional +p to wrap back into range
  localparam logic signed [9:0] K_ADJ = 10'(P_MOD - Q_OFF);
  localparam logic signed [9:0] P10   = 10'(P_MOD);

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } out_reg_t;

  logic [0:0]  state;
  logic [7:0]  key_q;
  out_reg_t    out_q;

  logic        key_legal;
  logic        chr_legal;
  logic        accept;
  logic        drain;
  logic signed [9:0] t_raw;
  logic signed [9:0] t_fix;
  logic [7:0]  enc_data;

  assign key_legal  = (secret_key != 8'd0) && (secret_key < P8);
  assign chr_legal  = (ptxt >= CHR_LO) && (ptxt <= CHR_HI);
  assign ptxt_ready = (state == KEY_OK) && (mode == MODE_ENC) && !key_load &&
                      (!out_q.vld || ctxt_ready);
  assign accept     = ptxt_valid && ptxt_ready;
  assign drain      = out_q.vld && ctxt_ready;

  always_comb begin
    t_raw = $signed({2'b00, ptxt}) + K_ADJ - $signed({2'b00, key_q});
    t_fix = (t_raw < 10'sd0) ? (t_raw + P10) : t_raw;
    enc_data = t_fix[7:0];
  end

  // Key FSM: key_load is honoured in any state and always overrides the current key status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= NO_KEY;
      key_q              <= 8'd0;
      err_invalid_seckey <= 1'b0;
    end else if (key_load) begin
      if (key_legal) begin
        state              <= KEY_OK;
        key_q              <= secret_key;
        err_invalid_seckey <= 1'b0;
      end else begin
        state              <= NO_KEY;
        err_invalid_seckey <= 1'b1;
      end
    end
  end

  assign key_valid = (state == KEY_OK);

  // Output register: reload wins over drain so back-to-back characters stream at full rate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q                 <= '0;
      char_count            <= '0;
      err_invalid_ptxt_char <= 1'b0;
    end else begin
      err_invalid_ptxt_char <= accept && !chr_legal;
      if (accept && chr_legal) begin
        out_q.vld  <= 1'b1;
        out_q.data <= enc_data;
        char_count <= char_count + CNT_W'(1);
      end else if (drain) begin
        out_q <= '0;
      end
    end
  end

  assign ctxt_valid = out_q.vld;
  assign ctxt       = out_q.data;

endmodule
